// File: rtl/uvmt_cv32e40x_sl_trigger_debug_entry.sv
// ----------------------------------------------------------------------------
// uvmt_cv32e40x_sl_trigger_debug_entry
//
// Support logic downstream of the per-memory-operation trigger match stage.
// For every retired instruction it merges the execute-trigger match and all
// per-operation memory-trigger matches into one per-trigger match. It keeps
// sticky hit flags and a saturating count of hitting retirements. A small FSM
// checks that each trigger hit outside debug mode is followed by a debug-mode
// entry whose cause is "trigger".
//
// Ports:
//   clk_i                    clock
//   rst_i                    synchronous, active-high reset
//   rvfi_valid               an instruction retires this cycle (qualifies rvfi_*)
//   rvfi_dbg_mode            retiring instruction executed in debug mode
//   rvfi_dbg                 debug cause of the retiring instruction (2 = trigger)
//   trigger_match_mem_array  MAX_MEM_ACCESS slices of NUM_TRIGGERS memory matches
//   trigger_match_execute    execute-address match per trigger
//   tdata1_hit_clr           per-trigger pulse clearing the sticky hit flag
//   match_any_o              registered per-trigger match of the last cycle
//   hit_sticky_o             sticky per-trigger hit flags
//   state_o                  FSM state (IDLE=0, PENDING=1, HALTED=2)
//   expect_dbg_o             high while the FSM is in PENDING
//   dbg_entry_ok_o           one-cycle pulse: expected debug entry seen
//   dbg_entry_err_o          one-cycle pulse: debug entry missing or wrong cause
//   match_cnt_o              saturating count of hitting retirements
// ----------------------------------------------------------------------------

package uvmt_cv32e40x_sl_trigger_debug_entry_pkg;

    localparam int CORE_PARAM_DBG_NUM_TRIGGERS = 4;

    localparam logic [2:0] DBG_CAUSE_TRIGGER = 3'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PENDING = 2'd1,
        ST_HALTED  = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_e;

endpackage

module uvmt_cv32e40x_sl_trigger_debug_entry
    import uvmt_cv32e40x_sl_trigger_debug_entry_pkg::*;
#(
    parameter int NUM_TRIGGERS   = CORE_PARAM_DBG_NUM_TRIGGERS,
    parameter int MAX_MEM_ACCESS = 13,
    parameter int TIMEOUT        = 64
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   rvfi_valid,
    input  logic                                   rvfi_dbg_mode,
    input  logic [2:0]                             rvfi_dbg,
    input  logic [MAX_MEM_ACCESS*NUM_TRIGGERS-1:0] trigger_match_mem_array,
    input  logic [NUM_TRIGGERS-1:0]                trigger_match_execute,
    input  logic [NUM_TRIGGERS-1:0]                tdata1_hit_clr,
    output logic [NUM_TRIGGERS-1:0]                match_any_o,
    output logic [NUM_TRIGGERS-1:0]                hit_sticky_o,
    output logic [1:0]                             state_o,
    output logic                                   expect_dbg_o,
    output logic                                   dbg_entry_ok_o,
    output logic                                   dbg_entry_err_o,
    output logic [15:0]                            match_cnt_o
);

    localparam int                TIMER_W    = $clog2(TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    logic [NUM_TRIGGERS-1:0] match_now;
    logic                    hit;
    logic                    dbg_trig_entry;

    state_e                  state_q, state_d;
    logic [TIMER_W-1:0]      timer_q, timer_d;
    logic [NUM_TRIGGERS-1:0] match_any_q, match_any_d;
    logic [NUM_TRIGGERS-1:0] hit_sticky_q, hit_sticky_d;
    logic                    expect_dbg_q, expect_dbg_d;
    logic                    dbg_entry_ok_q, dbg_entry_ok_d;
    logic                    dbg_entry_err_q, dbg_entry_err_d;
    logic [15:0]             match_cnt_q, match_cnt_d;

    // Merge execute and all memory-operation matches; triggers never fire in
    // debug mode and nothing counts without a retirement.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
        match_now = trigger_match_execute;
        for (int k = 0; k < MAX_MEM_ACCESS; k++) begin
            match_now = match_now | trigger_match_mem_array[k*NUM_TRIGGERS +: NUM_TRIGGERS];
        end
        if (!rvfi_valid || rvfi_dbg_mode) begin
            match_now = '0;
        end
    end

    assign hit            = |match_now;
    assign dbg_trig_entry = rvfi_valid && rvfi_dbg_mode && (rvfi_dbg == DBG_CAUSE_TRIGGER);

    // Match bookkeeping, independent of the FSM.
    always_comb begin
        match_any_d  = match_now;
        // Set wins over a same-cycle clear.
        hit_sticky_d = (hit_sticky_q & ~tdata1_hit_clr) | match_now;
        match_cnt_d  = match_cnt_q;
        if (hit && (match_cnt_q != 16'hFFFF)) begin
            match_cnt_d = match_cnt_q + 16'd1;
        end
    end

    // Debug-entry checker FSM.
    always_comb begin
        state_d         = state_q;
        dbg_entry_ok_d  = 1'b0;
        dbg_entry_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hit) begin
                    state_d = ST_PENDING;
                end
            end
            ST_PENDING: begin
                // A retirement resolves the pending entry even on the timeout
                // cycle; it is never re-evaluated as a fresh hit.
                if (rvfi_valid) begin
                    if (dbg_trig_entry) begin
                        dbg_entry_ok_d = 1'b1;
                        state_d        = ST_HALTED;
                    end else begin
                        dbg_entry_err_d = 1'b1;
                        state_d         = ST_IDLE;
                    end
                end else if (timer_q == TIMER_LAST) begin
                    dbg_entry_err_d = 1'b1;
                    state_d         = ST_IDLE;
                end
            end
            ST_HALTED: begin
                // First retirement outside debug mode marks the exit; it may
                // itself be a new hit.
                if (rvfi_valid && !rvfi_dbg_mode) begin
                    state_d = hit ? ST_PENDING : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // PENDING is always entered from another state, where the timer is
        // held at zero, so entry starts counting from 0.
        timer_d      = (state_q == ST_PENDING) ? timer_q + 1'b1 : '0;
        expect_dbg_d = (state_d == ST_PENDING);
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (rst_i) begin
            state_q         <= ST_IDLE;
            timer_q         <= '0;
            match_any_q     <= '0;
            hit_sticky_q    <= '0;
            expect_dbg_q    <= 1'b0;
            dbg_entry_ok_q  <= 1'b0;
            dbg_entry_err_q <= 1'b0;
            match_cnt_q     <= '0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            match_any_q     <= match_any_d;
            hit_sticky_q    <= hit_sticky_d;
            expect_dbg_q    <= expect_dbg_d;
            dbg_entry_ok_q  <= dbg_entry_ok_d;
            dbg_entry_err_q <= dbg_entry_err_d;
            match_cnt_q     <= match_cnt_d;
        end
    end

    assign match_any_o     = match_any_q;
    assign hit_sticky_o    = hit_sticky_q;
    assign state_o         = state_q;
    assign expect_dbg_o    = expect_dbg_q;
    assign dbg_entry_ok_o  = dbg_entry_ok_q;
    assign dbg_entry_err_o = dbg_entry_err_q;
    assign match_cnt_o     = match_cnt_q;

endmodule

// File: tb/tb_uvmt_cv32e40x_sl_trigger_debug_entry.sv
// ----------------------------------------------------------------------------
// Directed testbench for uvmt_cv32e40x_sl_trigger_debug_entry with
// NUM_TRIGGERS=4, MAX_MEM_ACCESS=13, TIMEOUT=64. Inputs are driven 1 time unit
// after each rising edge; outputs are checked at the same point, so each check
// sees the reaction to the inputs of the previous cycle.
// ----------------------------------------------------------------------------
module tb_uvmt_cv32e40x_sl_trigger_debug_entry;

    localparam int NT = 4;
    localparam int MA = 13;
    localparam int TO = 64;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              rvfi_valid;
    logic              rvfi_dbg_mode;
    logic [2:0]        rvfi_dbg;
    logic [MA*NT-1:0]  trigger_match_mem_array;
    logic [NT-1:0]     trigger_match_execute;
    logic [NT-1:0]     tdata1_hit_clr;
    logic [NT-1:0]     match_any_o;
    logic [NT-1:0]     hit_sticky_o;
    logic [1:0]        state_o;
    logic              expect_dbg_o;
    logic              dbg_entry_ok_o;
    logic              dbg_entry_err_o;
    logic [15:0]       match_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;

    uvmt_cv32e40x_sl_trigger_debug_entry #(
        .NUM_TRIGGERS  (NT),
        .MAX_MEM_ACCESS(MA),
        .TIMEOUT       (TO)
    ) dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .rvfi_valid             (rvfi_valid),
        .rvfi_dbg_mode          (rvfi_dbg_mode),
        .rvfi_dbg               (rvfi_dbg),
        .trigger_match_mem_array(trigger_match_mem_array),
        .trigger_match_execute  (trigger_match_execute),
        .tdata1_hit_clr         (tdata1_hit_clr),
        .match_any_o            (match_any_o),
        .hit_sticky_o           (hit_sticky_o),
        .state_o                (state_o),
        .expect_dbg_o           (expect_dbg_o),
        .dbg_entry_ok_o         (dbg_entry_ok_o),
        .dbg_entry_err_o        (dbg_entry_err_o),
        .match_cnt_o            (match_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic valid, input logic dmode, input logic [2:0] cause,
                         input logic [MA*NT-1:0] mem, input logic [NT-1:0] exe,
                         input logic [NT-1:0] clr);
        rvfi_valid              = valid;
        rvfi_dbg_mode           = dmode;
        rvfi_dbg                = cause;
        trigger_match_mem_array = mem;
        trigger_match_execute   = exe;
        tdata1_hit_clr          = clr;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 3'd0, '0, '0, '0);
    endtask

    initial begin
        logic [MA*NT-1:0] mem_v;

        // ---------------- reset ----------------
        rst_i = 1'b1;
        idle();
        tick();
        tick();
        check("rst_state",    32'(state_o),         32'd0);
        check("rst_match",    32'(match_any_o),     32'd0);
        check("rst_sticky",   32'(hit_sticky_o),    32'd0);
        check("rst_cnt",      32'(match_cnt_o),     32'd0);
        check("rst_expect",   32'(expect_dbg_o),    32'd0);
        check("rst_ok",       32'(dbg_entry_ok_o),  32'd0);
        check("rst_err",      32'(dbg_entry_err_o), 32'd0);
        rst_i = 1'b0;
        tick();

        // ---------------- hit then correct entry ----------------
        mem_v = '0;
        mem_v[0] = 1'b1;
        drive(1'b1, 1'b0, 3'd0, mem_v, '0, '0);
        tick();
        check("t1_state_pend", 32'(state_o),      32'd1);
        check("t1_expect",     32'(expect_dbg_o), 32'd1);
        check("t1_match",      32'(match_any_o),  32'h1);
        check("t1_sticky",     32'(hit_sticky_o), 32'h1);
        check("t1_cnt",        32'(match_cnt_o),  32'd1);
        drive(1'b1, 1'b1, 3'd2, '0, '0, '0);
        tick();
        check("t1_ok",          32'(dbg_entry_ok_o),  32'd1);
        check("t1_no_err",      32'(dbg_entry_err_o), 32'd0);
        check("t1_state_halt",  32'(state_o),         32'd2);
        check("t1_expect_low",  32'(expect_dbg_o),    32'd0);
        check("t1_match_clear", 32'(match_any_o),     32'h0);
        idle();
        tick();
        check("t1_ok_pulse", 32'(dbg_entry_ok_o), 32'd0);
        check("t1_hold_halt", 32'(state_o),       32'd2);
        drive(1'b1, 1'b0, 3'd0, '0, '0, '0);
        tick();
        check("t1_exit_idle", 32'(state_o), 32'd0);

        // ---------------- wrong cause ----------------
        drive(1'b1, 1'b0, 3'd0, '0, 4'b0010, '0);
        tick();
        check("t2_state_pend", 32'(state_o),      32'd1);
        check("t2_cnt",        32'(match_cnt_o),  32'd2);
        check("t2_sticky",     32'(hit_sticky_o), 32'h3);
        drive(1'b1, 1'b1, 3'd1, '0, '0, '0);
        tick();
        check("t2_err",   32'(dbg_entry_err_o), 32'd1);
        check("t2_no_ok", 32'(dbg_entry_ok_o),  32'd0);
        check("t2_state", 32'(state_o),         32'd0);
        idle();
        tick();
        check("t2_err_pulse", 32'(dbg_entry_err_o), 32'd0);

        // ---------------- timeout ----------------
        drive(1'b1, 1'b0, 3'd0, '0, 4'b0100, '0);
        tick();
        check("t3_state_pend", 32'(state_o), 32'd1);
        check("t3_cnt",        32'(match_cnt_o), 32'd3);
        idle();
        for (int i = 0; i < TO - 1; i++) tick();
        check("t3_no_err_63",  32'(dbg_entry_err_o), 32'd0);
        check("t3_still_pend", 32'(state_o),         32'd1);
        tick();
        check("t3_err_64",   32'(dbg_entry_err_o), 32'd1);
        check("t3_idle_64",  32'(state_o),         32'd0);

        // Retirement on the last timer cycle takes the rvfi_valid path.
        drive(1'b1, 1'b0, 3'd0, '0, 4'b0100, '0);
        tick();
        check("t3b_cnt", 32'(match_cnt_o), 32'd4);
        idle();
        for (int i = 0; i < TO - 1; i++) tick();
        drive(1'b1, 1'b1, 3'd2, '0, '0, '0);
        tick();
        check("t3b_ok",    32'(dbg_entry_ok_o),  32'd1);
        check("t3b_noerr", 32'(dbg_entry_err_o), 32'd0);
        check("t3b_halt",  32'(state_o),         32'd2);

        // Exit debug mode with a hit: straight back to PENDING.
        drive(1'b1, 1'b0, 3'd0, '0, 4'b1000, '0);
        tick();
        check("t3c_pend",   32'(state_o),      32'd1);
        check("t3c_cnt",    32'(match_cnt_o),  32'd5);
        check("t3c_sticky", 32'(hit_sticky_o), 32'hF);
        drive(1'b1, 1'b0, 3'd0, '0, '0, '0);
        tick();
        check("t3c_err",  32'(dbg_entry_err_o), 32'd1);
        check("t3c_idle", 32'(state_o),         32'd0);

        // ---------------- debug mode masks everything ----------------
        drive(1'b1, 1'b1, 3'b111, '1, '1, '0);
        tick();
        check("t4_state", 32'(state_o),     32'd0);
        check("t4_cnt",   32'(match_cnt_o), 32'd5);
        check("t4_match", 32'(match_any_o), 32'h0);

        // ---------------- slice 12 only ----------------
        mem_v = '0;
        mem_v[12*NT + 1] = 1'b1;
        drive(1'b1, 1'b0, 3'd0, mem_v, '0, '0);
        tick();
        check("t5_match", 32'(match_any_o), 32'h2);
        check("t5_state", 32'(state_o),     32'd1);
        check("t5_cnt",   32'(match_cnt_o), 32'd6);
        drive(1'b1, 1'b1, 3'd2, '0, '0, '0);
        tick();
        check("t5_halt", 32'(state_o), 32'd2);

        // ---------------- sticky set/clear ----------------
        drive(1'b1, 1'b0, 3'd0, '0, 4'b0001, 4'b0001);
        tick();
        check("t6_set_wins", 32'(hit_sticky_o), 32'hF);
        check("t6_pend",     32'(state_o),      32'd1);
        check("t6_cnt",      32'(match_cnt_o),  32'd7);
        drive(1'b0, 1'b0, 3'd0, '0, '0, 4'b0001);
        tick();
        check("t6_clear", 32'(hit_sticky_o), 32'hE);

        // ---------------- reset mid-PENDING ----------------
        check("t7_pre_pend", 32'(state_o), 32'd1);
        rst_i = 1'b1;
        idle();
        tick();
        check("t7_state",  32'(state_o),         32'd0);
        check("t7_match",  32'(match_any_o),     32'h0);
        check("t7_sticky", 32'(hit_sticky_o),    32'h0);
        check("t7_cnt",    32'(match_cnt_o),     32'd0);
        check("t7_expect", 32'(expect_dbg_o),    32'd0);
        check("t7_ok",     32'(dbg_entry_ok_o),  32'd0);
        check("t7_err",    32'(dbg_entry_err_o), 32'd0);
        rst_i = 1'b0;
        tick();
        check("t7_no_late_err", 32'(dbg_entry_err_o), 32'd0);

        // ---------------- counter saturation ----------------
        drive(1'b1, 1'b0, 3'd0, '0, 4'b0001, '0);
        for (int i = 0; i < 65534; i++) tick();
        check("t8_cnt_fffe", 32'(match_cnt_o), 32'hFFFE);
        tick();
        check("t8_cnt_ffff", 32'(match_cnt_o), 32'hFFFF);
        tick();
        check("t8_cnt_hold", 32'(match_cnt_o), 32'hFFFF);
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uvmt_cv32e40x_sl_trigger_debug_entry.md
# uvmt_cv32e40x_sl_trigger_debug_entry

Support-logic block downstream of the per-memory-operation trigger match stage. It merges the execute-trigger vector and all per-operation memory-trigger vectors of each retired instruction into one per-trigger match, and keeps sticky hit flags and a saturating match count. A small FSM checks that every trigger match outside debug mode is followed by a debug-mode entry with cause "trigger". Its outputs feed assertions and coverage in the uvmt support logic.

## Interface
Parameters:
- NUM_TRIGGERS, default CORE_PARAM_DBG_NUM_TRIGGERS: number of triggers; must be 1 or more.
- MAX_MEM_ACCESS, default 13: number of memory-operation match slices per retired instruction.
- TIMEOUT, default 64: maximum number of cycles spent in PENDING before an error is flagged.

Ports:
- clk_i  in  1: clock.
- rst_i  in  1: reset, synchronous, active-high.
- rvfi_valid  in  1: an instruction retires this cycle. All other rvfi_* and match inputs are qualified by it.
- rvfi_dbg_mode  in  1: the retiring instruction executed in debug mode.
- rvfi_dbg  in  3: debug cause of the retiring instruction (3'd2 = trigger).
- trigger_match_mem_array  in  MAX_MEM_ACCESS*NUM_TRIGGERS: slice k occupies bits [k*NUM_TRIGGERS +: NUM_TRIGGERS] and holds the memory match of memory operation k.
- trigger_match_execute  in  NUM_TRIGGERS: execute-address match per trigger.
- tdata1_hit_clr  in  NUM_TRIGGERS: one-cycle pulse; clears the sticky hit flag of that trigger.
- match_any_o  out  NUM_TRIGGERS: registered per-trigger match of the last retirement.
- hit_sticky_o  out  NUM_TRIGGERS: sticky per-trigger hit flags.
- state_o  out  2: FSM state; IDLE=0, PENDING=1, HALTED=2.
- expect_dbg_o  out  1: high while the FSM is in PENDING.
- dbg_entry_ok_o  out  1: one-cycle pulse when the expected debug entry is seen.
- dbg_entry_err_o  out  1: one-cycle pulse when the expected debug entry is missing or has the wrong cause.
- match_cnt_o  out  16: count of retirements with any match; saturates.

## Operation
- Combinational match_now = trigger_match_execute OR the bitwise OR of all MAX_MEM_ACCESS slices. match_now is forced to 0 when rvfi_valid=0 or rvfi_dbg_mode=1. Triggers never fire in debug mode.
- A retirement "hits" when |match_now=1.
- match_any_o is loaded with match_now every cycle, so it is 0 in the cycle after a non-retiring cycle.
- hit_sticky_o[t] is set by match_now[t] and cleared by tdata1_hit_clr[t]. If both occur in the same cycle for the same trigger, set wins.
- match_cnt_o increments by 1 per hitting retirement, regardless of FSM state. It saturates at 16'hFFFF.
- An internal timer is $clog2(TIMEOUT+1) bits wide. It is cleared on entry to PENDING and increments every cycle while in PENDING.
- IDLE:
  - A hitting retirement goes to PENDING.
  - Otherwise stay in IDLE.
- PENDING:
  - rvfi_valid with rvfi_dbg_mode=1 and rvfi_dbg=3'd2: pulse dbg_entry_ok_o and go to HALTED.
  - rvfi_valid with any other combination: pulse dbg_entry_err_o and go to IDLE. This retirement is not re-evaluated as a new hit, even if it matches.
  - No rvfi_valid and timer = TIMEOUT-1: pulse dbg_entry_err_o and go to IDLE.
  - If rvfi_valid and the timeout coincide, the rvfi_valid rule wins.
- HALTED:
  - rvfi_valid with rvfi_dbg_mode=0 means debug mode has been exited. A hitting retirement goes directly to PENDING; otherwise go to IDLE.
  - All other cycles: stay in HALTED.
- Encoding 3 is unreachable; if it is ever entered, the next cycle returns to IDLE.

## Timing
- All outputs are registered. Every reaction appears in the cycle after the triggering input cycle.
- A hit in cycle N gives match_any_o, hit_sticky_o, match_cnt_o, state_o=PENDING and expect_dbg_o at N+1.
- dbg_entry_ok_o and dbg_entry_err_o are high for exactly one cycle and are never high together.
- A timeout error is flagged TIMEOUT cycles after entry to PENDING.
- Reset (rst_i high at a clock edge) sets, at the next edge:
  - state_o = IDLE and the timer to 0;
  - match_any_o, hit_sticky_o, expect_dbg_o, dbg_entry_ok_o, dbg_entry_err_o and match_cnt_o all to 0.
- Reset takes priority over every other event, including a reset that arrives mid-PENDING. No error pulse is produced for an abandoned PENDING.

## Test plan
- Hit then correct entry: load hit on trigger 0 (mem slice 0 = 1), then the next retirement has dbg_mode=1 and rvfi_dbg=2 -> one PENDING cycle, then dbg_entry_ok_o=1 and state_o=2; match_cnt_o=1; hit_sticky_o[0]=1.
- Wrong cause: hit, then the next retirement has dbg_mode=1 and rvfi_dbg=1 -> dbg_entry_err_o pulse and state_o=0.
- Timeout: hit, then no rvfi_valid for 64 cycles -> dbg_entry_err_o asserted exactly 64 cycles after PENDING entry; a retirement at cycle 63 takes the rvfi_valid path instead.
- Debug-mode and slice coverage:
  - Retirement with dbg_mode=1 and all inputs all-ones -> no state change; counter unchanged.
  - Match only in slice 12 -> match_any_o set for that trigger.
- Sticky and saturation:
  - tdata1_hit_clr[0] together with a trigger-0 hit -> hit_sticky_o[0] stays 1; a clear alone clears it.
  - 65536 hits -> match_cnt_o holds 16'hFFFF.
- Reset mid-PENDING -> all outputs 0 at the next cycle; no error pulse.
